// File: rtl/pic_pkg.sv
// Shared definitions for the PIC16C57 instruction-cycle sequencer:
// controller states, Q-phase constants and the NOP opcode used for pipeline flushes.
package pic_pkg;

    typedef enum logic [1:0] {
        ST_RST   = 2'd0,
        ST_RUN   = 2'd1,
        ST_SLEEP = 2'd2
    } state_t;

    localparam logic [1:0] Q1 = 2'd0;
    localparam logic [1:0] Q2 = 2'd1;
    localparam logic [1:0] Q3 = 2'd2;
    localparam logic [1:0] Q4 = 2'd3;

    localparam logic [11:0] NOP_OPCODE = 12'h000;

    function automatic logic [1:0] nextPhase(input logic [1:0] i_q);
        logic [1:0] w_n;
        case (i_q)
            Q1:      w_n = Q2;
            Q2:      w_n = Q3;
            Q3:      w_n = Q4;
            default: w_n = Q1;
        endcase
        return w_n;
    endfunction

endpackage

// File: rtl/q_phase_counter.sv
// Two-bit Q1..Q4 wrap counter with hold and synchronous clear; clear wins over hold.
module q_phase_counter
    import pic_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_hold,
    input  logic       i_clear,
    output logic [1:0] o_q
);

    logic [1:0] r_q;

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_q <= Q1;
        end else if (!i_hold) begin
            r_q <= nextPhase(r_q);
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/pic_cycle_ctrl.sv
// Instruction-cycle sequencer: Q-phase generation, fetch/PC strobes, branch/skip
// flush of the prefetched word, reset start-up and SLEEP/wake handling.
module pic_cycle_ctrl
    import pic_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       branch_req,
    input  logic       skip_req,
    input  logic       sleep_req,
    input  logic       wake,
    output logic [1:0] q,
    output logic       load_ins,
    output logic       sel_code,
    output logic       pc_inc,
    output logic       pc_load,
    output logic       exec_en,
    output logic       sleeping
);

    state_t     r_state;
    state_t     w_state_next;
    logic [1:0] w_q;
    logic       r_sleep_pend;
    logic       w_sleep_pend_next;
    logic       r_load_ins;
    logic       r_sel_code;
    logic       r_pc_inc;
    logic       r_pc_load;
    logic       w_load_ins_next;
    logic       w_sel_code_next;
    logic       w_pc_inc_next;
    logic       w_pc_load_next;
    logic       w_hold;
    logic       w_clear;

    // Phase stalls in SLEEP and is forced back to Q1 on any SLEEP entry or exit.
    assign w_hold  = (r_state == ST_SLEEP);
    assign w_clear = (w_state_next == ST_SLEEP) ||
                     ((r_state == ST_SLEEP) && (w_state_next == ST_RUN));

    q_phase_counter u_qpc (
        .clk     (clk),
        .rst     (rst),
        .i_hold  (w_hold),
        .i_clear (w_clear),
        .o_q     (w_q)
    );

    // Strobe values are computed in Q3 so that the registered copies are high only during Q4.
    always_comb begin
        w_state_next      = r_state;
        w_sleep_pend_next = r_sleep_pend;
        w_load_ins_next   = 1'b0;
        w_sel_code_next   = 1'b0;
        w_pc_inc_next     = 1'b0;
        w_pc_load_next    = 1'b0;

        case (r_state)
            ST_RST: begin
                w_sleep_pend_next = 1'b0;
                if (w_q == Q3) begin
                    w_load_ins_next = 1'b1;
                    w_pc_inc_next   = 1'b1;
                end
                if (w_q == Q4) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_q == Q3) begin
                    w_load_ins_next   = 1'b1;
                    w_sel_code_next   = branch_req | skip_req;
                    w_pc_load_next    = branch_req;
                    w_pc_inc_next     = ~branch_req;
                    w_sleep_pend_next = sleep_req;
                end
                if (w_q == Q4) begin
                    w_sleep_pend_next = 1'b0;
                    if (r_sleep_pend) begin
                        w_state_next = ST_SLEEP;
                    end
                end
            end
            ST_SLEEP: begin
                w_sleep_pend_next = 1'b0;
                if (wake) begin
                    w_state_next = ST_RUN;
                end
            end
            default: begin
                w_state_next      = ST_RST;
                w_sleep_pend_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_RST;
            r_sleep_pend <= 1'b0;
            r_load_ins   <= 1'b0;
            r_sel_code   <= 1'b0;
            r_pc_inc     <= 1'b0;
            r_pc_load    <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_sleep_pend <= w_sleep_pend_next;
            r_load_ins   <= w_load_ins_next;
            r_sel_code   <= w_sel_code_next;
            r_pc_inc     <= w_pc_inc_next;
            r_pc_load    <= w_pc_load_next;
        end
    end

    assign q        = w_q;
    assign load_ins = r_load_ins;
    assign sel_code = r_sel_code;
    assign pc_inc   = r_pc_inc;
    assign pc_load  = r_pc_load;
    assign exec_en  = (r_state == ST_RUN);
    assign sleeping = (r_state == ST_SLEEP);

endmodule

// File: tb/tb_pic_cycle_ctrl.sv
// Self-checking bench for pic_cycle_ctrl: directed start-up/branch/skip/sleep/reset
// sequences followed by randomized instruction cycles against an instruction-level model.
module tb_pic_cycle_ctrl;
    import pic_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       branch_req;
    logic       skip_req;
    logic       sleep_req;
    logic       wake;
    logic [1:0] q;
    logic       load_ins;
    logic       sel_code;
    logic       pc_inc;
    logic       pc_load;
    logic       exec_en;
    logic       sleeping;

    int checks = 0;
    int errors = 0;

    localparam logic [7:0] RESET_VEC = 8'h00;

    pic_cycle_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .branch_req (branch_req),
        .skip_req   (skip_req),
        .sleep_req  (sleep_req),
        .wake       (wake),
        .q          (q),
        .load_ins   (load_ins),
        .sel_code   (sel_code),
        .pc_inc     (pc_inc),
        .pc_load    (pc_load),
        .exec_en    (exec_en),
        .sleeping   (sleeping)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed {q,ld,sel,inc,pcl,ex,slp}=%b expected=%b t=%0t",
                     tag, observed, expected, $time);
        end
    endtask

    function automatic logic [7:0] outVec();
        return {q, load_ins, sel_code, pc_inc, pc_load, exec_en, sleeping};
    endfunction

    function automatic logic [7:0] mk(input logic [1:0] eq, input bit ld, input bit sel,
                                      input bit inc, input bit pcl, input bit ex, input bit slp);
        return {eq, ld, sel, inc, pcl, ex, slp};
    endfunction

    task automatic applyStimulus(input bit br, input bit sk, input bit sl, input bit wk);
        branch_req = br;
        skip_req   = sk;
        sleep_req  = sl;
        wake       = wk;
    endtask

    task automatic applyGarbage(input bit allowWake);
        applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), allowWake ? 1'($urandom_range(0, 1)) : 1'b0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // outcome: 0 = still running, 1 = entered SLEEP, 2 = reset taken at Q3
    task automatic runInstrCycle(input bit first, input bit br, input bit sk, input bit sl,
                                 input bit abortAtQ3, output int outcome);
        bit ex;
        ex = !first;
        outcome = 0;
        applyGarbage(1'b1);
        step();
        checkOutput("q2phase", outVec(), mk(Q2, 0, 0, 0, 0, ex, 0));
        applyGarbage(1'b1);
        step();
        checkOutput("q3phase", outVec(), mk(Q3, 0, 0, 0, 0, ex, 0));
        if (abortAtQ3) begin
            applyStimulus(1'b1, sk, sl, 1'b0);
            rst = 1'b1;
            step();
            checkOutput("rstAtQ3", outVec(), RESET_VEC);
            rst = 1'b0;
            outcome = 2;
            return;
        end
        applyStimulus(br, sk, sl, 1'($urandom_range(0, 1)));
        step();
        if (first)
            checkOutput("rstFetch", outVec(), mk(Q4, 1, 0, 1, 0, 0, 0));
        else
            checkOutput("q4strobe", outVec(), mk(Q4, 1, br | sk, !br, br, 1, 0));
        applyGarbage(1'b1);
        step();
        if (!first && sl) begin
            checkOutput("sleepEntry", outVec(), mk(Q1, 0, 0, 0, 0, 0, 1));
            outcome = 1;
        end else begin
            checkOutput("q1phase", outVec(), mk(Q1, 0, 0, 0, 0, 1, 0));
        end
    endtask

    // returns 1 when the stay ended in a reset instead of a wake
    task automatic sleepPhase(input int n, input bit resetInSleep, output bit wasReset);
        wasReset = 1'b0;
        for (int i = 0; i < n; i++) begin
            applyGarbage(1'b0);
            step();
            checkOutput("sleepHold", outVec(), mk(Q1, 0, 0, 0, 0, 0, 1));
        end
        if (resetInSleep) begin
            applyGarbage(1'b1);
            rst = 1'b1;
            step();
            checkOutput("rstInSleep", outVec(), RESET_VEC);
            rst = 1'b0;
            wasReset = 1'b1;
        end else begin
            applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
            step();
            checkOutput("wake", outVec(), mk(Q1, 0, 0, 0, 0, 1, 0));
            wake = 1'b0;
        end
    endtask

    initial begin
        int  outcome;
        bit  first;
        bit  wasReset;

        $display("[TB] flushed fetches load NOP opcode %03h", NOP_OPCODE);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        step();
        checkOutput("reset0", outVec(), RESET_VEC);
        applyGarbage(1'b1);
        step();
        checkOutput("reset1", outVec(), RESET_VEC);
        rst = 1'b0;

        runInstrCycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, outcome);
        for (int i = 0; i < 5; i++) runInstrCycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, outcome);
        runInstrCycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, outcome);
        runInstrCycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, outcome);
        runInstrCycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, outcome);
        runInstrCycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, outcome);
        runInstrCycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, outcome);
        checkOutput("sleepOutcome", 8'(outcome), 8'd1);
        sleepPhase(20, 1'b0, wasReset);
        runInstrCycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, outcome);
        runInstrCycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, outcome);
        sleepPhase(3, 1'b0, wasReset);
        runInstrCycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, outcome);
        runInstrCycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, outcome);
        runInstrCycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, outcome);
        sleepPhase(4, 1'b1, wasReset);

        first = 1'b1;
        for (int i = 0; i < 200; i++) begin
            bit br, sk, sl, ab;
            br = ($urandom_range(0, 3) == 0);
            sk = ($urandom_range(0, 3) == 0);
            sl = ($urandom_range(0, 7) == 0);
            ab = ($urandom_range(0, 19) == 0);
            runInstrCycle(first, br, sk, sl, ab, outcome);
            first = (outcome == 2);
            if (outcome == 1) begin
                sleepPhase(int'($urandom_range(1, 8)), ($urandom_range(0, 3) == 0), wasReset);
                first = wasReset;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
